// File: rtl/stream_mux_pkg.sv
// Shared constants for the stream_mux_nx1 slice.
//   ARB_FIXED / ARB_RR : arbitration mode selectors
//   STATS_W            : width of each per-channel beat counter
//   ch_w()             : channel-index width, never less than one bit
package stream_mux_pkg;
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;
  localparam int STATS_W   = 16;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/stream_mux_nx1_if.sv
// Stream bus between N producers, the mux and one consumer.
//   in_valid/in_data/in_ready : per-channel producer handshake
//   out_valid/out_data/out_ch/out_ready : registered consumer handshake
// Modports: slave = mux view, master = producer/consumer (bench) view.
interface stream_mux_nx1_if
  import stream_mux_pkg::*;
#(
  parameter int N     = 3,
  parameter int WIDTH = 1,
  parameter int CW    = ch_w(N)
);
  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [CW-1:0]      out_ch;
  logic               out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/stream_mux_nx1_rr_arbiter.sv
// rr_arbiter: combinational grant for stream_mux_nx1.
//   req_i   : per-channel requests (in_valid)
//   last_i  : index of the last channel served (round-robin only)
//   grant_o : one-hot grant, zero when nothing requests
//   idx_o   : binary index of the granted channel
// ARB_MODE 0 = lowest index wins; 1 = search from last_i+1, wrapping.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int N        = 3,
  parameter int ARB_MODE = ARB_FIXED,
  parameter int CW       = ch_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [CW-1:0] last_i,
  output logic [N-1:0]  grant_o,
  output logic [CW-1:0] idx_o
);

  int            base;
  logic [CW-1:0] pos;
  logic          found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    pos     = '0;
    base    = (ARB_MODE == ARB_RR) ? int'(last_i) + 1 : 0;
    // Walk the channels in priority order; the first requester wins.
    for (int k = 0; k < N; k++) begin
      pos = CW'((base + k) % N);
      if (!found && req_i[pos]) begin
        grant_o[pos] = 1'b1;
        found        = 1'b1;
      end
    end
  end

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_o[i]) idx_o = CW'(i);
    end
  end

endmodule

// File: rtl/stream_mux_nx1.sv
// stream_mux_nx1: N-channel stream multiplexer with built-in arbitration
// and a registered output stage.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : stream_mux_nx1_if.slave (inputs, in_ready, registered output)
//   cnt_clr    : (STREAM_MUX_STATS_EN only) synchronous clear of counters
//   grant_cnt  : (STREAM_MUX_STATS_EN only) N x 16-bit saturating beat counts
// Optional feature macro: STREAM_MUX_STATS_EN.
module stream_mux_nx1
  import stream_mux_pkg::*;
#(
  parameter int N        = 3,
  parameter int WIDTH    = 1,
  parameter int ARB_MODE = ARB_FIXED,
  parameter int CW       = ch_w(N)
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef STREAM_MUX_STATS_EN
  input  logic                 cnt_clr,
  output logic [N*STATS_W-1:0] grant_cnt,
`endif
  stream_mux_nx1_if.slave      bus
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CW-1:0]    out_ch_q, out_ch_d;
  logic [CW-1:0]    last_q, last_d;

  logic             load;
  logic [N-1:0]     grant;
  logic [CW-1:0]    grant_idx;
  logic [WIDTH-1:0] sel_data;

  rr_arbiter #(.N(N), .ARB_MODE(ARB_MODE), .CW(CW)) u_arb (
    .req_i   (bus.in_valid),
    .last_i  (last_q),
    .grant_o (grant),
    .idx_o   (grant_idx)
  );

  // Output register can accept a beat when empty or being drained.
  assign load = !out_valid_q || bus.out_ready;

  // Held low during reset so no producer believes a beat was taken.
  assign bus.in_ready = (load && !rst) ? grant : '0;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) sel_data = bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    last_d      = last_q;
    if (load) begin
      out_valid_d = |grant;
      // On a drain without refill, data and channel keep their last values.
      if (|grant) begin
        out_data_d = sel_data;
        out_ch_d   = grant_idx;
        if (ARB_MODE == ARB_RR) last_d = grant_idx;
      end
    end
  end

  // Output stage register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      last_q      <= CW'(N - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      last_q      <= last_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

`ifdef STREAM_MUX_STATS_EN
  logic [STATS_W-1:0] cnt_q [N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else if (cnt_clr) begin
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.in_ready[i] && bus.in_valid[i] && (cnt_q[i] != '1))
          cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_cnt
    assign grant_cnt[g*STATS_W +: STATS_W] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_stream_mux_nx1.sv
// Bench for stream_mux_nx1: u0 is fixed priority, u1 is round-robin,
// both N=3, WIDTH=8. Optional counters are exercised when
// STREAM_MUX_STATS_EN is defined.
module tb_stream_mux_nx1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  stream_mux_nx1_if #(.N(3), .WIDTH(8)) m0 ();
  stream_mux_nx1_if #(.N(3), .WIDTH(8)) m1 ();

`ifdef STREAM_MUX_STATS_EN
  logic        cnt_clr0 = 1'b0;
  logic        cnt_clr1 = 1'b0;
  logic [47:0] gcnt0;
  logic [47:0] gcnt1;
`endif

  stream_mux_nx1 #(.N(3), .WIDTH(8), .ARB_MODE(0)) u0 (
    .clk       (clk),
    .rst       (rst),
`ifdef STREAM_MUX_STATS_EN
    .cnt_clr   (cnt_clr0),
    .grant_cnt (gcnt0),
`endif
    .bus       (m0)
  );

  stream_mux_nx1 #(.N(3), .WIDTH(8), .ARB_MODE(1)) u1 (
    .clk       (clk),
    .rst       (rst),
`ifdef STREAM_MUX_STATS_EN
    .cnt_clr   (cnt_clr1),
    .grant_cnt (gcnt1),
`endif
    .bus       (m1)
  );

  typedef struct {
    logic [2:0]  iv;
    logic [23:0] data;
    logic        ordy;
    logic [2:0]  ir;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  ch;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at posedge+1: drive, check in_ready, clock, check registers.
  task automatic step0(input string nm, input vec_t v);
    m0.in_valid  = v.iv;
    m0.in_data   = v.data;
    m0.out_ready = v.ordy;
    #3;
    chk({nm, " in_ready"}, 64'(m0.in_ready), 64'(v.ir));
    @(posedge clk); #1;
    chk({nm, " out_valid"}, 64'(m0.out_valid), 64'(v.ov));
    chk({nm, " out_data"}, 64'(m0.out_data), 64'(v.od));
    chk({nm, " out_ch"}, 64'(m0.out_ch), 64'(v.ch));
  endtask

  task automatic step1(input string nm, input logic [2:0] iv, input logic ordy,
                       input logic [2:0] ir, input logic ov, input logic [1:0] ch);
    logic [23:0] d;
    logic [7:0]  od;
    d = 24'h32_21_10;
    od = d[ch*8 +: 8];
    m1.in_valid  = iv;
    m1.in_data   = d;
    m1.out_ready = ordy;
    #3;
    chk({nm, " in_ready"}, 64'(m1.in_ready), 64'(ir));
    @(posedge clk); #1;
    chk({nm, " out_valid"}, 64'(m1.out_valid), 64'(ov));
    chk({nm, " out_ch"}, 64'(m1.out_ch), 64'(ch));
    chk({nm, " out_data"}, 64'(m1.out_data), 64'(od));
  endtask

  initial begin
    tbl[0]  = '{3'b111, 24'hB2A111, 1'b1, 3'b001, 1'b1, 8'h11, 2'd0};
    tbl[1]  = '{3'b110, 24'hB2A111, 1'b1, 3'b010, 1'b1, 8'hA1, 2'd1};
    tbl[2]  = '{3'b110, 24'hB2A111, 1'b1, 3'b010, 1'b1, 8'hA1, 2'd1};
    tbl[3]  = '{3'b110, 24'hB2A111, 1'b0, 3'b000, 1'b1, 8'hA1, 2'd1};
    tbl[4]  = '{3'b100, 24'hB2A111, 1'b0, 3'b000, 1'b1, 8'hA1, 2'd1};
    tbl[5]  = '{3'b100, 24'hB2A111, 1'b1, 3'b100, 1'b1, 8'hB2, 2'd2};
    tbl[6]  = '{3'b000, 24'hB2A111, 1'b1, 3'b000, 1'b0, 8'hB2, 2'd2};
    tbl[7]  = '{3'b000, 24'hB2A111, 1'b0, 3'b000, 1'b0, 8'hB2, 2'd2};
    tbl[8]  = '{3'b010, 24'hB2C35A, 1'b0, 3'b010, 1'b1, 8'hC3, 2'd1};
    tbl[9]  = '{3'b001, 24'hB2C35A, 1'b0, 3'b000, 1'b1, 8'hC3, 2'd1};
    tbl[10] = '{3'b001, 24'hB2C35A, 1'b1, 3'b001, 1'b1, 8'h5A, 2'd0};

    m0.in_valid = 3'b111; m0.in_data = 24'hB2A111; m0.out_ready = 1'b1;
    m1.in_valid = 3'b000; m1.in_data = '0;         m1.out_ready = 1'b1;

    // Reset state with all channels requesting
    repeat (2) @(posedge clk); #1;
    chk("reset out_valid", 64'(m0.out_valid), 64'd0);
    chk("reset out_ch", 64'(m0.out_ch), 64'd0);
    chk("reset out_data", 64'(m0.out_data), 64'd0);
    chk("reset in_ready", 64'(m0.in_ready), 64'd0);
    rst = 1'b0;

    // Fixed-priority table
    for (int i = 0; i < 11; i++) step0($sformatf("fp row%0d", i), tbl[i]);
    m0.in_valid = 3'b000;

    // Round-robin rotation, idle cycles, lone requester
    step1("rr0", 3'b111, 1'b1, 3'b001, 1'b1, 2'd0);
    step1("rr1", 3'b111, 1'b1, 3'b010, 1'b1, 2'd1);
    step1("rr2", 3'b111, 1'b1, 3'b100, 1'b1, 2'd2);
    step1("rr3", 3'b111, 1'b1, 3'b001, 1'b1, 2'd0);
    step1("rr4", 3'b111, 1'b1, 3'b010, 1'b1, 2'd1);
    step1("rr5", 3'b111, 1'b1, 3'b100, 1'b1, 2'd2);
    step1("rr idle a", 3'b000, 1'b1, 3'b000, 1'b0, 2'd2);
    step1("rr resume a", 3'b111, 1'b1, 3'b001, 1'b1, 2'd0);
    step1("rr idle b", 3'b000, 1'b1, 3'b000, 1'b0, 2'd0);
    step1("rr resume b", 3'b111, 1'b1, 3'b010, 1'b1, 2'd1);
    step1("rr lone0", 3'b100, 1'b1, 3'b100, 1'b1, 2'd2);
    step1("rr lone1", 3'b100, 1'b1, 3'b100, 1'b1, 2'd2);
    step1("rr lone2", 3'b100, 1'b1, 3'b100, 1'b1, 2'd2);

    // Backpressure then release with all sources pending
    for (int i = 0; i < 4; i++)
      step1($sformatf("bp stall%0d", i), 3'b111, 1'b0, 3'b000, 1'b1, 2'd2);
    step1("bp go0", 3'b111, 1'b1, 3'b001, 1'b1, 2'd0);
    step1("bp go1", 3'b111, 1'b1, 3'b010, 1'b1, 2'd1);
    step1("bp go2", 3'b111, 1'b1, 3'b100, 1'b1, 2'd2);

    // Asynchronous reset between edges while a beat is held
    m1.in_valid = 3'b000; m1.out_ready = 1'b0;
    #2;
    chk("pre-reset out_valid", 64'(m1.out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("async rst out_valid", 64'(m1.out_valid), 64'd0);
    chk("async rst out_ch", 64'(m1.out_ch), 64'd0);
    chk("async rst out_data", 64'(m1.out_data), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    step1("post-rst rr0", 3'b111, 1'b1, 3'b001, 1'b1, 2'd0);
    step1("post-rst rr1", 3'b111, 1'b1, 3'b010, 1'b1, 2'd1);
    m1.in_valid = 3'b000;

`ifdef STREAM_MUX_STATS_EN
    m0.in_valid = 3'b001; m0.in_data = 24'h0000AA; m0.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("cnt after 3", 64'(gcnt0[15:0]), 64'd3);
    cnt_clr0 = 1'b1;
    @(posedge clk); #1;
    cnt_clr0 = 1'b0;
    chk("cnt_clr beats grant", 64'(gcnt0[15:0]), 64'd0);
    repeat (70000) @(posedge clk);
    #1;
    chk("cnt saturate", 64'(gcnt0[15:0]), 64'hFFFF);
    chk("cnt ch1 idle", 64'(gcnt0[31:16]), 64'd0);
    cnt_clr0 = 1'b1;
    @(posedge clk); #1;
    cnt_clr0 = 1'b0;
    chk("cnt_clr after sat", 64'(gcnt0[15:0]), 64'd0);
    @(posedge clk); #1;
    chk("cnt restart", 64'(gcnt0[15:0]), 64'd1);
    m0.in_valid = 3'b000;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
